avalon_packet_enforcer: RTL

Parametrised Avalon-ST protocol enforcer sitting between an untrusted packet source and trusted downstream logic. It accepts any beat sequence on `untrusted_msg` and guarantees `enforced_msg` carries only well-formed packets: every packet opens with sop, closes with eop, is at most MAX_PKT_BEATS beats long, and has empty = 0 on non-eop beats. Violations are repaired by dropping beats or by closing the open packet early, and each violation is flagged. Full ready/valid backpressure is supported.

---
 rtl/avalon_packet_enforcer_pkg.sv | 31 +++
 rtl/avalon_st_if.sv | 16 +
 rtl/avalon_packet_enforcer_stats.sv | 31 +++
 rtl/avalon_packet_enforcer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/avalon_packet_enforcer_pkg.sv
// Shared types for avalon_packet_enforcer: FSM states, holding-slot layout and
// the saturating-counter helper used by the optional statistics block.
package avalon_packet_enforcer_pack;

    localparam int STAT_WIDTH      = 32;
    // Slots are sized for the widest supported beat; narrower instances leave
    // the upper bits constant zero, which synthesis removes.
    localparam int SLOT_DATA_BYTES = 64;
    localparam int SLOT_DATA_W     = SLOT_DATA_BYTES * 8;
    localparam int SLOT_EMPTY_W    = $clog2(SLOT_DATA_BYTES);

    typedef enum logic [1:0] {
        WAIT_FOR_SOP,
        IN_PACKET,
        DROP_TO_EOP
    } state_t;

    typedef struct packed {
        logic                    valid;
        logic                    is_final;
        logic                    sop;
        logic                    eop;
        logic [SLOT_DATA_W-1:0]  data;
        logic [SLOT_EMPTY_W-1:0] empty;
    } slot_t;

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
        return (&value) ? value : value + STAT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle (valid/ready, sop/eop, data, empty) shared by source and sink.
interface avalon_st_if #(
    parameter int DATA_WIDTH_IN_BYTES = 8
);
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             ready;
    logic                             sop;
    logic                             eop;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic [EMPTY_W-1:0]               empty;

    modport master (output valid, sop, eop, data, empty, input ready);
    modport slave  (input valid, sop, eop, data, empty, output ready);
endinterface

// File: rtl/avalon_packet_enforcer_stats.sv
// Saturating 32-bit error counters for avalon_packet_enforcer, one per error pulse.
module avalon_enforcer_stats
    import avalon_packet_enforcer_pack::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  missing_sop,
    input  logic                  double_sop,
    input  logic                  oversize,
    input  logic                  dropped_beat,
    output logic [STAT_WIDTH-1:0] stat_missing_sop,
    output logic [STAT_WIDTH-1:0] stat_double_sop,
    output logic [STAT_WIDTH-1:0] stat_oversize,
    output logic [STAT_WIDTH-1:0] stat_dropped_beats
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_missing_sop   <= '0;
            stat_double_sop    <= '0;
            stat_oversize      <= '0;
            stat_dropped_beats <= '0;
        end else begin
            if (missing_sop)  stat_missing_sop   <= sat_inc(stat_missing_sop);
            if (double_sop)   stat_double_sop    <= sat_inc(stat_double_sop);
            if (oversize)     stat_oversize      <= sat_inc(stat_oversize);
            if (dropped_beat) stat_dropped_beats <= sat_inc(stat_dropped_beats);
        end
    end

endmodule

// File: rtl/avalon_packet_enforcer.sv
// avalon_packet_enforcer: repairs an untrusted Avalon-ST stream into well-formed packets.
// Error counters are built only when AVALON_PACKET_ENFORCER_STATS_EN is defined.
//
// state        | meaning
// WAIT_FOR_SOP | no packet open; beats without sop are dropped
// IN_PACKET    | packet open; newest beat parked in H until its successor arrives
// DROP_TO_EOP  | packet truncated at MAX_PKT_BEATS; discard until eop or a new sop
module avalon_packet_enforcer
    import avalon_packet_enforcer_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 8,
    parameter int MAX_PKT_BEATS       = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    avalon_st_if.slave            untrusted_msg,
    avalon_st_if.master           enforced_msg,
    output logic                  missing_sop_error,
    output logic                  double_sop_error,
    output logic                  oversize_error,
    output logic [STAT_WIDTH-1:0] stat_missing_sop,
    output logic [STAT_WIDTH-1:0] stat_double_sop,
    output logic [STAT_WIDTH-1:0] stat_oversize,
    output logic [STAT_WIDTH-1:0] stat_dropped_beats
);

    localparam int DATA_W  = DATA_WIDTH_IN_BYTES * 8;
    localparam int EMPTY_W = $clog2(DATA_WIDTH_IN_BYTES);
    localparam int CW      = $clog2(MAX_PKT_BEATS + 1);
    localparam logic [CW:0] MAX_BEATS = (CW+1)'(MAX_PKT_BEATS);

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW:0]   count_inc;
    slot_t         h_q, h_d, o_q, o_d;

    logic acc, o_free, move, load, drop, start_pkt;
    logic new_final, new_force_eop, force_old_eop;
    logic missing_d, double_d, oversize_d;
    logic unused_slot;

    assign acc                 = untrusted_msg.valid & untrusted_msg.ready;
    assign o_free              = ~o_q.valid | enforced_msg.ready;
    assign untrusted_msg.ready = ~h_q.valid | o_free;
    assign count_inc           = {1'b0, count_q} + (CW+1)'(1);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        drop          = 1'b0;
        start_pkt     = 1'b0;
        new_final     = 1'b0;
        new_force_eop = 1'b0;
        force_old_eop = 1'b0;
        missing_d     = 1'b0;
        double_d      = 1'b0;
        oversize_d    = 1'b0;

        if (acc) begin
            case (state_q)
                WAIT_FOR_SOP: begin
                    start_pkt = untrusted_msg.sop;
                    drop      = ~untrusted_msg.sop;
                    missing_d = ~untrusted_msg.sop;
                end
                IN_PACKET: begin
                    if (untrusted_msg.sop) begin
                        start_pkt     = 1'b1;
                        force_old_eop = 1'b1;
                        double_d      = 1'b1;
                    end else if (untrusted_msg.eop) begin
                        new_final = 1'b1;
                        state_d   = WAIT_FOR_SOP;
                    end else if (count_inc == MAX_BEATS) begin
                        new_final     = 1'b1;
                        new_force_eop = 1'b1;
                        oversize_d    = 1'b1;
                        state_d       = DROP_TO_EOP;
                    end else begin
                        count_d = count_inc[CW-1:0];
                    end
                end
                DROP_TO_EOP: begin
                    start_pkt = untrusted_msg.sop;
                    drop      = ~untrusted_msg.sop;
                    if (!untrusted_msg.sop && untrusted_msg.eop) state_d = WAIT_FOR_SOP;
                end
                default: begin
                    drop    = 1'b1;
                    state_d = WAIT_FOR_SOP;
                end
            endcase

            // A sop always opens a fresh packet, whatever state it arrived in.
            if (start_pkt) begin
                new_final = untrusted_msg.eop;
                if (untrusted_msg.eop) begin
                    state_d = WAIT_FOR_SOP;
                end else begin
                    state_d = IN_PACKET;
                    count_d = CW'(1);
                end
            end
        end

        load = acc & ~drop;
        move = h_q.valid & o_free & (h_q.is_final | acc);

        o_d = o_q;
        if (move) begin
            o_d = h_q;
            if (force_old_eop) begin
                o_d.eop   = 1'b1;
                o_d.empty = '0;
            end
        end else if (o_free) begin
            o_d = '0;
        end

        h_d = h_q;
        if (load) begin
            h_d                     = '0;
            h_d.valid               = 1'b1;
            h_d.is_final            = new_final;
            h_d.sop                 = untrusted_msg.sop;
            h_d.eop                 = untrusted_msg.eop | new_force_eop;
            h_d.data[DATA_W-1:0]    = untrusted_msg.data;
            h_d.empty[EMPTY_W-1:0]  = (untrusted_msg.eop & ~new_force_eop) ? untrusted_msg.empty : '0;
        end else if (move) begin
            h_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= WAIT_FOR_SOP;
            count_q           <= '0;
            h_q               <= '0;
            o_q               <= '0;
            missing_sop_error <= 1'b0;
            double_sop_error  <= 1'b0;
            oversize_error    <= 1'b0;
        end else begin
            state_q           <= state_d;
            count_q           <= count_d;
            h_q               <= h_d;
            o_q               <= o_d;
            missing_sop_error <= missing_d;
            double_sop_error  <= double_d;
            oversize_error    <= oversize_d;
        end
    end

    assign enforced_msg.valid = o_q.valid;
    assign enforced_msg.sop   = o_q.valid & o_q.sop;
    assign enforced_msg.eop   = o_q.valid & o_q.eop;
    assign enforced_msg.data  = o_q.valid ? o_q.data[DATA_W-1:0] : '0;
    assign enforced_msg.empty = o_q.valid ? o_q.empty[EMPTY_W-1:0] : '0;

    // Padding bits of the wide slot and the final flag never reach a port.
    assign unused_slot = o_q.is_final ^ (^o_q.data) ^ (^o_q.empty);

`ifdef AVALON_PACKET_ENFORCER_STATS_EN
    logic drop_pulse;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) drop_pulse <= 1'b0;
        else      drop_pulse <= drop;
    end

    avalon_enforcer_stats u_stats (
        .clk                (clk),
        .rst                (rst),
        .missing_sop        (missing_sop_error),
        .double_sop         (double_sop_error),
        .oversize           (oversize_error),
        .dropped_beat       (drop_pulse),
        .stat_missing_sop   (stat_missing_sop),
        .stat_double_sop    (stat_double_sop),
        .stat_oversize      (stat_oversize),
        .stat_dropped_beats (stat_dropped_beats)
    );
`else
    assign stat_missing_sop   = '0;
    assign stat_double_sop    = '0;
    assign stat_oversize      = '0;
    assign stat_dropped_beats = '0;
`endif

endmodule
